// File: rtl/spi_job_loader.sv
// spi_job_loader
//   Register bank behind the SPI slave front-end. Assembles a mining job
//   header from byte writes, hands it to the hash core over a valid/ready
//   handshake, captures the result nonce and exposes status to the host.
//
// Ports
//   clk, reset            : system clock, asynchronous active-low reset
//   reg_num/wr_data/wr_en : register address, write byte, write strobe (level)
//   rd_data               : registered read byte (1 clk latency from reg_num)
//   job_header            : flattened header, byte 0 in bits [7:0]
//   job_valid/job_ready   : job handshake to the core
//   core_abort            : single-cycle abort pulse to the core
//   result_valid/nonce    : result pulse from the core
//   irq                   : high while a result is waiting (DONE)
//
// Address map (A = HEADER_BYTES): 0..A-1 header, A CTRL (wo), A+1 STATUS,
// A+2..A+5 nonce little-endian, everything else reads 0.
module spi_job_loader #(
    parameter int HEADER_BYTES = 80
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [6:0]                reg_num,
    input  logic [7:0]                wr_data,
    input  logic                      wr_en,
    output logic [7:0]                rd_data,
    output logic [HEADER_BYTES*8-1:0] job_header,
    output logic                      job_valid,
    input  logic                      job_ready,
    output logic                      core_abort,
    input  logic                      result_valid,
    input  logic [31:0]               result_nonce,
    output logic                      irq
);

    typedef enum logic [1:0] {IDLE, PENDING, RUNNING, DONE} state_e;

    localparam int         AW     = (HEADER_BYTES > 1) ? $clog2(HEADER_BYTES) : 1;
    localparam logic [6:0] A_CTRL = 7'(HEADER_BYTES);
    localparam logic [6:0] A_STAT = A_CTRL + 7'd1;
    localparam logic [6:0] A_N0   = A_CTRL + 7'd2;
    localparam logic [6:0] A_N3   = A_CTRL + 7'd5;

    state_e                         state_q, state_d;
    logic [HEADER_BYTES-1:0][7:0]   header_q, header_d;
    logic [31:0]                    nonce_q, nonce_d;
    logic                           wr_en_q;
    logic                           done_q, done_d;
    logic                           werr_q, werr_d;
    logic                           job_valid_q, job_valid_d;
    logic                           abort_q, abort_d;
    logic                           irq_q, irq_d;
    logic [7:0]                     rd_q, rd_d;

    logic           wr_fire, busy, hdr_sel, ctrl_wr, abort_fire;
    logic [AW-1:0]  hdr_idx;
    logic [1:0]     nidx;

    always_comb begin
        // Rising edge of the level strobe: a held wr_en writes only once.
        wr_fire    = wr_en & ~wr_en_q;
        busy       = (state_q == PENDING) || (state_q == RUNNING);
        hdr_sel    = reg_num < A_CTRL;
        hdr_idx    = reg_num[AW-1:0];
        nidx       = 2'(reg_num - A_N0);
        ctrl_wr    = wr_fire && (reg_num == A_CTRL);
        abort_fire = ctrl_wr && wr_data[1];

        state_d  = state_q;
        header_d = header_q;
        nonce_d  = nonce_q;
        done_d   = done_q;
        werr_d   = werr_q;
        abort_d  = 1'b0;

        // Header is frozen while the core owns the job.
        if (wr_fire && hdr_sel) begin
            if (busy) werr_d = 1'b1;
            else      header_d[hdr_idx] = wr_data;
        end

        if (ctrl_wr) begin
            if (wr_data[1]) begin
                // Only a job actually held by the core needs an abort pulse.
                abort_d = busy;
                state_d = IDLE;
            end else begin
                if (wr_data[2]) begin
                    done_d = 1'b0;
                    werr_d = 1'b0;
                    if (state_q == DONE) state_d = IDLE;
                end
                if (wr_data[0]) begin
                    if (busy) begin
                        werr_d = 1'b1;
                    end else begin
                        done_d  = 1'b0;
                        state_d = PENDING;
                    end
                end
            end
        end

        // Core-side events; a same-cycle abort takes precedence.
        if (!abort_fire) begin
            if (state_q == PENDING && job_ready) state_d = RUNNING;
            if (state_q == RUNNING && result_valid) begin
                nonce_d = result_nonce;
                done_d  = 1'b1;
                state_d = DONE;
            end
        end

        job_valid_d = (state_d == PENDING);
        irq_d       = (state_d == DONE);

        rd_d = 8'h00;
        if (hdr_sel)                             rd_d = header_q[hdr_idx];
        else if (reg_num == A_STAT)              rd_d = {4'h0, job_valid_q, werr_q, done_q, busy};
        else if (reg_num >= A_N0 && reg_num <= A_N3) rd_d = nonce_q[{nidx, 3'b000} +: 8];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            header_q    <= '0;
            nonce_q     <= '0;
            wr_en_q     <= 1'b0;
            done_q      <= 1'b0;
            werr_q      <= 1'b0;
            job_valid_q <= 1'b0;
            abort_q     <= 1'b0;
            irq_q       <= 1'b0;
            rd_q        <= 8'h00;
        end else begin
            state_q     <= state_d;
            header_q    <= header_d;
            nonce_q     <= nonce_d;
            wr_en_q     <= wr_en;
            done_q      <= done_d;
            werr_q      <= werr_d;
            job_valid_q <= job_valid_d;
            abort_q     <= abort_d;
            irq_q       <= irq_d;
            rd_q        <= rd_d;
        end
    end

    assign job_header = header_q;
    assign job_valid  = job_valid_q;
    assign core_abort = abort_q;
    assign irq        = irq_q;
    assign rd_data    = rd_q;

endmodule

// File: tb/tb_spi_job_loader.sv
// Scoreboard bench for spi_job_loader: the driver applies SPI-side and
// core-side transactions, updates a transaction-level model of the register
// bank and queues the expected observations; a monitor on the falling edge
// pops and compares them against the DUT.
module tb_spi_job_loader;
    localparam int HB = 80;
    localparam int S_IDLE = 0, S_PEND = 1, S_RUN = 2, S_DONE = 3;
    localparam int K_RD = 0, K_JV = 1, K_IRQ = 2, K_AB = 3, K_HDR = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [6:0]      reg_num;
    logic [7:0]      wr_data;
    logic            wr_en;
    logic [7:0]      rd_data;
    logic [HB*8-1:0] job_header;
    logic            job_valid;
    logic            job_ready;
    logic            core_abort;
    logic            result_valid;
    logic [31:0]     result_nonce;
    logic            irq;

    always #5 clk = ~clk;

    spi_job_loader #(.HEADER_BYTES(HB)) dut (
        .clk(clk), .reset(reset), .reg_num(reg_num), .wr_data(wr_data),
        .wr_en(wr_en), .rd_data(rd_data), .job_header(job_header),
        .job_valid(job_valid), .job_ready(job_ready), .core_abort(core_abort),
        .result_valid(result_valid), .result_nonce(result_nonce), .irq(irq)
    );

    typedef struct {
        int    kind;
        int    idx;
        int    val;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // ---------------- reference model (transaction level) ----------------
    logic [7:0]  m_hdr [HB];
    logic [31:0] m_nonce;
    bit          m_done, m_werr;
    int          m_st;

    function automatic bit m_busy();
        return (m_st == S_PEND) || (m_st == S_RUN);
    endfunction

    function automatic int m_read(int a);
        if (a < HB)      return int'(m_hdr[a]);
        if (a == HB + 1) return ((m_st == S_PEND) ? 8 : 0) + (m_werr ? 4 : 0) +
                                (m_done ? 2 : 0) + (m_busy() ? 1 : 0);
        if (a >= HB + 2 && a <= HB + 5) return int'((m_nonce >> (8 * (a - HB - 2))) & 32'hFF);
        return 0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < HB; i++) m_hdr[i] = 8'h00;
        m_nonce = 0; m_done = 0; m_werr = 0; m_st = S_IDLE;
    endtask

    // Effect of one fired write; returns whether an abort pulse must follow.
    task automatic m_write(input int a, input int d, output bit ab);
        ab = 0;
        if (a < HB) begin
            if (m_busy()) m_werr = 1;
            else          m_hdr[a] = 8'(d);
        end else if (a == HB) begin
            if (d & 2) begin
                ab   = m_busy();
                m_st = S_IDLE;
            end else begin
                if (d & 4) begin
                    m_done = 0; m_werr = 0;
                    if (m_st == S_DONE) m_st = S_IDLE;
                end
                if (d & 1) begin
                    if (m_busy()) m_werr = 1;
                    else begin m_done = 0; m_st = S_PEND; end
                end
            end
        end
    endtask

    // ---------------- scoreboard plumbing ----------------
    task automatic push(input int kind, input int idx, input int val, input string name);
        exp_t e;
        e.kind = kind; e.idx = idx; e.val = val; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic chk_ctl(input bit ab);
        push(K_JV,  0, (m_st == S_PEND) ? 1 : 0, "job_valid");
        push(K_IRQ, 0, (m_st == S_DONE) ? 1 : 0, "irq");
        push(K_AB,  0, ab ? 1 : 0, "core_abort");
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   act;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                K_RD:    act = int'(rd_data);
                K_JV:    act = int'(job_valid);
                K_IRQ:   act = int'(irq);
                K_AB:    act = int'(core_abort);
                default: act = int'(job_header[8*e.idx +: 8]);
            endcase
            n_cmp++;
            if (act != e.val) begin
                n_err++;
                $display("FAIL %s[%0d] at %0t: got 0x%0h expected 0x%0h",
                         e.name, e.idx, $time, act, e.val);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    // with_res drives a result pulse on the firing cycle; only used with ABORT.
    task automatic do_wr(input int a, input int d, input int hold,
                         input bit with_res, input logic [31:0] rn);
        bit ab;
        reg_num = 7'(a); wr_data = 8'(d); wr_en = 1'b1;
        if (with_res) begin result_valid = 1'b1; result_nonce = rn; end
        tick();
        result_valid = 1'b0;
        m_write(a, d, ab);
        chk_ctl(ab);
        for (int i = 1; i < hold; i++) begin
            wr_data = 8'($urandom);
            tick();
            chk_ctl(0);
        end
        wr_en = 1'b0;
        tick();
        chk_ctl(0);
    endtask

    task automatic do_rd(input int a);
        reg_num = 7'(a);
        tick();
        push(K_RD, a, m_read(a), "rd_data");
        chk_ctl(0);
    endtask

    task automatic do_ready();
        job_ready = 1'b1;
        tick();
        job_ready = 1'b0;
        if (m_st == S_PEND) m_st = S_RUN;
        chk_ctl(0);
    endtask

    task automatic do_result(input logic [31:0] n);
        result_valid = 1'b1; result_nonce = n;
        tick();
        result_valid = 1'b0;
        if (m_st == S_RUN) begin m_nonce = n; m_done = 1; m_st = S_DONE; end
        chk_ctl(0);
    endtask

    task automatic do_hdr_chk(input int i);
        push(K_HDR, i, int'(m_hdr[i]), "hdr");
    endtask

    initial begin
        reset = 1'b0; reg_num = '0; wr_data = '0; wr_en = 1'b0;
        job_ready = 1'b0; result_valid = 1'b0; result_nonce = '0;
        m_reset();
        repeat (3) tick();
        chk_ctl(0);
        reset = 1'b1;
        tick();
        for (int a = HB; a <= HB + 5; a++) do_rd(a);
        do_rd(0);
        do_rd(127);

        // Fill header with held strobes and changing wr_data after the fire.
        for (int i = 0; i < HB; i++) do_wr(i, i, 3, 0, 0);
        do_hdr_chk(0); do_hdr_chk(HB - 1); do_hdr_chk(37);
        do_rd(5); do_rd(HB - 1);

        // Start, hold off ready, then accept.
        do_wr(HB, 8'h01, 1, 0, 0);
        repeat (3) begin tick(); chk_ctl(0); end
        do_rd(HB + 1);
        do_ready();
        do_rd(HB + 1);
        do_ready();                 // ready outside PENDING is ignored

        // Header write while running is dropped and flagged.
        do_wr(3, 8'hAA, 2, 0, 0);
        do_hdr_chk(3); do_rd(3); do_rd(HB + 1);
        do_result(32'hDEADBEEF);
        for (int a = HB + 2; a <= HB + 5; a++) do_rd(a);
        do_rd(HB + 1);

        // START+CLEAR from DONE, then abort racing a result.
        do_wr(HB, 8'h05, 1, 0, 0);
        do_rd(HB + 1);
        do_ready();
        do_wr(HB, 8'h03, 1, 1, 32'h12345678);
        do_rd(HB + 2); do_rd(HB + 5); do_rd(HB + 1);
        do_result(32'h11111111);    // result outside RUNNING is ignored
        do_rd(HB + 2);
        do_wr(HB, 8'h02, 1, 0, 0);  // abort in IDLE: no pulse

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 11);
            case (r)
                0, 1, 2: do_wr($urandom_range(0, HB - 1), $urandom_range(0, 255),
                               $urandom_range(1, 3), 0, 0);
                3:       do_wr($urandom_range(0, 127), $urandom_range(0, 255), 1, 0, 0);
                4, 5:    do_wr(HB, $urandom_range(0, 255), $urandom_range(1, 2), 0, 0);
                6:       do_rd($urandom_range(0, 127));
                7:       do_rd($urandom_range(HB, HB + 5));
                8:       do_ready();
                9:       do_result($urandom);
                10:      do_wr(HB, 2 | $urandom_range(0, 255), 1, 1, $urandom);
                default: do_hdr_chk($urandom_range(0, HB - 1));
            endcase
        end

        // Asynchronous reset in the middle of PENDING.
        do_wr(HB, 8'h02, 1, 0, 0);
        do_wr(HB, 8'h01, 1, 0, 0);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        m_reset();
        chk_ctl(0);
        do_hdr_chk(HB - 1);
        tick();
        reset = 1'b1;
        tick();
        do_rd(HB + 1); do_rd(HB - 1); do_rd(HB + 2);

        repeat (2) tick();
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
